// File: rtl/regs_mc_if.sv
// APB bus bundle between the interconnect and the multi-channel UART CSR block.
interface regs_mc_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [31:0]       pwdata;
  logic [3:0]        pstrb;
  logic [31:0]       prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/regs_mc.sv
// APB CSR block for CH_N UART channels: per-channel DATA/STAT/CTRL/INTSTAT/INTEN,
// global IRQSUM/ID, registered response FSM with a FIFO wait-state timeout.
module regs_mc #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned CH_N     = 4,
  parameter int unsigned TIMEOUT  = 15,
  parameter logic [31:0] ID_VALUE = 32'hCAFE0666
) (
  input  logic                clk,
  input  logic                rst,
  regs_mc_if.slave            bus,
  input  logic [CH_N-1:0]     ch_rx_valid_i,
  input  logic [8*CH_N-1:0]   ch_rx_data_i,
  output logic [CH_N-1:0]     ch_rx_ren_o,
  input  logic [CH_N-1:0]     ch_tx_wready_i,
  output logic [CH_N-1:0]     ch_tx_wen_o,
  output logic [8*CH_N-1:0]   ch_tx_data_o,
  input  logic [CH_N-1:0]     ch_busy_i,
  output logic [2*CH_N-1:0]   ch_baud_o,
  output logic [CH_N-1:0]     ch_txen_o,
  output logic [CH_N-1:0]     ch_rxen_o,
  output logic [CH_N-1:0]     ch_txst_o,
  input  logic [2*CH_N-1:0]   ch_int_set_i,
  output logic [CH_N-1:0]     irq_ch_o,
  output logic                irq_o
);

  localparam int unsigned     ChW        = (CH_N > 1) ? $clog2(CH_N) : 1;
  localparam int unsigned     IdxW       = ADDR_W - 5;
  localparam logic [IdxW-1:0] ChLim      = IdxW'(CH_N);
  localparam logic [ADDR_W-1:0] AddrIrqSum = ADDR_W'(32'hFF8);
  localparam logic [ADDR_W-1:0] AddrId     = ADDR_W'(32'hFFC);
  localparam logic [7:0]      TimeoutVal = 8'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e          state_q;
  logic [7:0]      timer_q;
  logic [ChW-1:0]  fch_q;
  logic            fwr_q;
  logic            pready_q, pslverr_q;
  logic [31:0]     prdata_q;
  logic [CH_N-1:0] rx_ren_q, tx_wen_q, txst_q;
  logic [7:0]      tx_data_q;

  logic [1:0]      intstat_q [CH_N];
  logic [1:0]      inten_q   [CH_N];
  logic [1:0]      baud_q    [CH_N];
  logic [CH_N-1:0] txen_q, rxen_q;

  logic [IdxW-1:0] idx;
  logic [ChW-1:0]  ch;
  logic [4:0]      off;
  logic            is_ch, sel_data, sel_stat, sel_ctrl, sel_ints, sel_inten;
  logic            sel_irqs, sel_id, mapped;
  logic            acc, wr, ctrl_we, ints_we, inten_we;
  logic [31:0]     rd_val, fifo_rd;
  logic            fifo_ok;

  always_comb begin
    idx       = bus.paddr[ADDR_W-1:5];
    ch        = bus.paddr[5 +: ChW];
    off       = bus.paddr[4:0];
    is_ch     = idx < ChLim;
    sel_data  = is_ch && (off == 5'h00);
    sel_stat  = is_ch && (off == 5'h04);
    sel_ctrl  = is_ch && (off == 5'h08);
    sel_ints  = is_ch && (off == 5'h0C);
    sel_inten = is_ch && (off == 5'h10);
    sel_irqs  = bus.paddr == AddrIrqSum;
    sel_id    = bus.paddr == AddrId;
    mapped    = sel_data | sel_stat | sel_ctrl | sel_ints | sel_inten | sel_irqs | sel_id;

    acc      = (state_q == StIdle) && bus.psel && bus.penable;
    wr       = acc && bus.pwrite && bus.pstrb[0];
    ctrl_we  = wr && sel_ctrl;
    ints_we  = wr && sel_ints;
    inten_we = wr && sel_inten;

    rd_val = '0;
    if (sel_data) begin
      rd_val = {24'h0, ch_rx_data_i[{ch, 3'b000} +: 8]};
    end else if (sel_stat) begin
      rd_val = {29'h0, ch_tx_wready_i[ch], ch_rx_valid_i[ch], ch_busy_i[ch]};
    end else if (sel_ctrl) begin
      rd_val = {25'h0, 1'b0, rxen_q[ch], txen_q[ch], 2'b00, baud_q[ch]};
    end else if (sel_ints) begin
      rd_val = {30'h0, intstat_q[ch]};
    end else if (sel_inten) begin
      rd_val = {30'h0, inten_q[ch]};
    end else if (sel_irqs) begin
      rd_val = 32'(irq_ch_o);
    end else if (sel_id) begin
      rd_val = ID_VALUE;
    end

    fifo_ok = fwr_q ? ch_tx_wready_i[fch_q] : ch_rx_valid_i[fch_q];
    fifo_rd = {24'h0, ch_rx_data_i[{fch_q, 3'b000} +: 8]};
  end

  always_comb begin
    irq_ch_o  = '0;
    ch_baud_o = '0;
    for (int c = 0; c < CH_N; c++) begin
      irq_ch_o[c]          = |(intstat_q[c] & inten_q[c]);
      ch_baud_o[2*c +: 2]  = baud_q[c];
    end
  end

  assign irq_o        = |irq_ch_o;
  assign ch_txen_o    = txen_q;
  assign ch_rxen_o    = rxen_q;
  assign ch_txst_o    = txst_q;
  assign ch_rx_ren_o  = rx_ren_q;
  assign ch_tx_wen_o  = tx_wen_q;
  assign ch_tx_data_o = {CH_N{tx_data_q}};
  assign bus.prdata   = prdata_q;
  assign bus.pready   = pready_q;
  assign bus.pslverr  = pslverr_q;

  // Channel register file; a same-cycle set beats a write-1-to-clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int c = 0; c < CH_N; c++) begin
        intstat_q[c] <= '0;
        inten_q[c]   <= '0;
        baud_q[c]    <= '0;
      end
      txen_q <= '0;
      rxen_q <= '0;
    end else begin
      for (int c = 0; c < CH_N; c++) begin
        intstat_q[c] <= (intstat_q[c] &
                         ~((ints_we && (ch == ChW'(c))) ? bus.pwdata[1:0] : 2'b00)) |
                        ch_int_set_i[2*c +: 2];
      end
      if (ctrl_we) begin
        baud_q[ch] <= bus.pwdata[1:0];
        txen_q[ch] <= bus.pwdata[4];
        rxen_q[ch] <= bus.pwdata[5];
      end
      if (inten_we) inten_q[ch] <= bus.pwdata[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      fch_q     <= '0;
      fwr_q     <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      rx_ren_q  <= '0;
      tx_wen_q  <= '0;
      txst_q    <= '0;
      tx_data_q <= '0;
    end else begin
      rx_ren_q <= '0;
      tx_wen_q <= '0;
      txst_q   <= '0;
      unique case (state_q)
        StIdle: begin
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          prdata_q  <= '0;
          timer_q   <= '0;
          if (acc) begin
            if (ctrl_we && bus.pwdata[6]) txst_q[ch] <= 1'b1;
            if (!mapped) begin
              state_q   <= StResp;
              pready_q  <= 1'b1;
              pslverr_q <= 1'b1;
            end else if (sel_data && bus.pwrite) begin
              fch_q <= ch;
              fwr_q <= 1'b1;
              if (!bus.pstrb[0]) begin
                state_q  <= StResp;
                pready_q <= 1'b1;
              end else if (ch_tx_wready_i[ch]) begin
                tx_wen_q[ch] <= 1'b1;
                tx_data_q    <= bus.pwdata[7:0];
                state_q      <= StResp;
                pready_q     <= 1'b1;
              end else begin
                state_q <= StWait;
                timer_q <= 8'd1;
              end
            end else if (sel_data) begin
              fch_q <= ch;
              fwr_q <= 1'b0;
              if (ch_rx_valid_i[ch]) begin
                rx_ren_q[ch] <= 1'b1;
                prdata_q     <= rd_val;
                state_q      <= StResp;
                pready_q     <= 1'b1;
              end else begin
                state_q <= StWait;
                timer_q <= 8'd1;
              end
            end else begin
              state_q  <= StResp;
              pready_q <= 1'b1;
              if (!bus.pwrite) prdata_q <= rd_val;
            end
          end
        end
        StWait: begin
          if (!bus.psel) begin
            state_q <= StIdle;
            timer_q <= '0;
          end else if (fifo_ok) begin
            if (fwr_q) begin
              tx_wen_q[fch_q] <= 1'b1;
              tx_data_q       <= bus.pwdata[7:0];
            end else begin
              rx_ren_q[fch_q] <= 1'b1;
              prdata_q        <= fifo_rd;
            end
            state_q  <= StResp;
            pready_q <= 1'b1;
          end else if (timer_q == TimeoutVal) begin
            state_q   <= StResp;
            pready_q  <= 1'b1;
            pslverr_q <= 1'b1;
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end
        StResp: begin
          state_q   <= StIdle;
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          prdata_q  <= '0;
          timer_q   <= '0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  logic unused_bus_bits;
  assign unused_bus_bits = ^{bus.pwdata[31:8], bus.pstrb[3:1]};

endmodule

// File: tb/tb_regs_mc.sv
// Directed self-checking bench for regs_mc: vector table plus multi-cycle FIFO/reset sequences.
module tb_regs_mc;
  localparam int unsigned CH_N    = 4;
  localparam int unsigned TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  regs_mc_if #(.ADDR_W(16)) bus ();

  logic [CH_N-1:0]   ch_rx_valid, ch_rx_ren, ch_tx_wready, ch_tx_wen, ch_busy;
  logic [CH_N-1:0]   ch_txen, ch_rxen, ch_txst, irq_ch;
  logic [8*CH_N-1:0] ch_rx_data, ch_tx_data;
  logic [2*CH_N-1:0] ch_baud, ch_int_set;
  logic              irq;

  regs_mc #(.ADDR_W(16), .CH_N(CH_N), .TIMEOUT(TIMEOUT), .ID_VALUE(32'hCAFE0666)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .ch_rx_valid_i  (ch_rx_valid),
    .ch_rx_data_i   (ch_rx_data),
    .ch_rx_ren_o    (ch_rx_ren),
    .ch_tx_wready_i (ch_tx_wready),
    .ch_tx_wen_o    (ch_tx_wen),
    .ch_tx_data_o   (ch_tx_data),
    .ch_busy_i      (ch_busy),
    .ch_baud_o      (ch_baud),
    .ch_txen_o      (ch_txen),
    .ch_rxen_o      (ch_rxen),
    .ch_txst_o      (ch_txst),
    .ch_int_set_i   (ch_int_set),
    .irq_ch_o       (irq_ch),
    .irq_o          (irq)
  );

  int tests = 0;
  int fails = 0;
  int ren_cnt = 0, wen_cnt = 0, txst2_cnt = 0, pready_cnt = 0;
  logic [7:0] last_tx = '0;

  always @(negedge clk) begin
    ren_cnt    += $countones(ch_rx_ren);
    wen_cnt    += $countones(ch_tx_wen);
    txst2_cnt  += int'(ch_txst[2]);
    pready_cnt += int'(bus.pready);
    if (ch_tx_wen[3]) last_tx = ch_tx_data[31:24];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic apb(input bit wr, input logic [15:0] a, input logic [31:0] wd,
                     input logic [3:0] st, output logic [31:0] rd, output logic err,
                     output int lat);
    @(negedge clk);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr;
    bus.paddr = a; bus.pwdata = wd; bus.pstrb = st;
    @(negedge clk);
    bus.penable = 1'b1;
    chk("pready_low_in_decode", {31'h0, bus.pready}, 32'h0);
    lat = 0; rd = '0; err = 1'b0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.pready && lat < 40);
    if (bus.pready) begin
      rd  = bus.prdata;
      err = bus.pslverr;
    end else begin
      tests++; fails++;
      $display("FAIL apb_timeout: addr 0x%04h got no pready, required pready within 40", a);
    end
    bus.psel = 1'b0; bus.penable = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t vecs[$];

  logic [31:0] rd;
  logic        err;
  int          lat, r0, w0, p0;

  initial begin
    vecs.push_back('{0, 16'h0FFC, 32'h0,  4'hF, 32'hCAFE0666, 0}); // ID
    vecs.push_back('{0, 16'h0048, 32'h0,  4'hF, 32'h0,        0}); // ch2 CTRL reset
    vecs.push_back('{0, 16'h0044, 32'h0,  4'hF, 32'h5,        0}); // ch2 STAT busy|tx_wready
    vecs.push_back('{0, 16'h0FF8, 32'h0,  4'hF, 32'h0,        0}); // IRQSUM
    vecs.push_back('{0, 16'h00A0, 32'h0,  4'hF, 32'h0,        1}); // channel 5 unmapped
    vecs.push_back('{1, 16'h00A0, 32'hFF, 4'hF, 32'h0,        1});
    vecs.push_back('{0, 16'h0034, 32'h0,  4'hF, 32'h0,        1}); // ch1 offset 0x14
    vecs.push_back('{1, 16'h0FFC, 32'h0,  4'hF, 32'h0,        0}); // ro write ignored
    vecs.push_back('{0, 16'h0FFC, 32'h0,  4'hF, 32'hCAFE0666, 0});
    vecs.push_back('{1, 16'h0050, 32'h3,  4'hF, 32'h0,        0}); // ch2 INTEN
    vecs.push_back('{0, 16'h0050, 32'h0,  4'hF, 32'h3,        0});
    vecs.push_back('{1, 16'h0050, 32'h0,  4'hF, 32'h0,        0});
    vecs.push_back('{0, 16'h0050, 32'h0,  4'hF, 32'h0,        0});
    vecs.push_back('{0, 16'h0028, 32'h0,  4'hF, 32'h0,        0}); // ch1 CTRL

    // Reset with random activity on every input
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = '0; bus.pwdata = '0; bus.pstrb = '0;
    repeat (4) begin
      @(negedge clk);
      bus.psel = 1'($urandom); bus.penable = 1'($urandom); bus.pwrite = 1'($urandom);
      bus.paddr = 16'($urandom); bus.pwdata = $urandom; bus.pstrb = 4'($urandom);
      ch_rx_valid = 4'($urandom); ch_rx_data = $urandom; ch_tx_wready = 4'($urandom);
      ch_busy = 4'($urandom); ch_int_set = 8'($urandom);
    end
    @(negedge clk);
    chk("rst_pready",  {31'h0, bus.pready}, 32'h0);
    chk("rst_pslverr", {31'h0, bus.pslverr}, 32'h0);
    chk("rst_prdata",  bus.prdata, 32'h0);
    chk("rst_irq",     {31'h0, irq}, 32'h0);
    chk("rst_strobes", {20'h0, ch_rx_ren, ch_tx_wen, ch_txst}, 32'h0);
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.pstrb = '0;
    ch_rx_valid = '0; ch_rx_data = '0; ch_tx_wready = 4'b0100;
    ch_busy = 4'b0100; ch_int_set = '0;
    @(negedge clk);
    rst = 1'b1;

    apb(0, 16'h0008, 0, 4'hF, rd, err, lat);
    chk("rst_ctrl0_read", rd, 32'h0);
    chk("rst_ctrl0_lat", lat, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, rd, err, lat);
      chk($sformatf("vec%0d_err", i), {31'h0, err}, {31'h0, vecs[i].exp_err});
      chk($sformatf("vec%0d_lat", i), lat, 1);
      if (!vecs[i].wr) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
    end

    // Channel 2 CTRL with self-clearing TXST
    p0 = txst2_cnt;
    apb(1, 16'h0048, 32'h73, 4'hF, rd, err, lat);
    repeat (2) @(negedge clk);
    chk("ch2_baud", {30'h0, ch_baud[5:4]}, 32'h3);
    chk("ch2_txen_rxen", {30'h0, ch_txen[2], ch_rxen[2]}, 32'h3);
    chk("ch2_txst_pulses", txst2_cnt - p0, 1);
    apb(0, 16'h0048, 0, 4'hF, rd, err, lat);
    chk("ch2_ctrl_read", rd, 32'h33);
    apb(1, 16'h0048, 32'h0, 4'h0, rd, err, lat);
    apb(0, 16'h0048, 0, 4'hF, rd, err, lat);
    chk("ch2_ctrl_nostrb", rd, 32'h33);

    // Channel 1 interrupt masking and set-beats-clear
    @(negedge clk); ch_int_set = 8'h08;
    @(negedge clk); ch_int_set = 8'h00;
    apb(0, 16'h002C, 0, 4'hF, rd, err, lat);
    chk("ch1_intstat", rd, 32'h2);
    chk("ch1_irq_masked", {31'h0, irq}, 32'h0);
    apb(1, 16'h0030, 32'h2, 4'hF, rd, err, lat);
    @(negedge clk);
    chk("ch1_irq_ch", {28'h0, irq_ch}, 32'h2);
    chk("ch1_irq", {31'h0, irq}, 32'h1);
    apb(0, 16'h0FF8, 0, 4'hF, rd, err, lat);
    chk("irqsum", rd, 32'h2);
    @(negedge clk);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = 16'h002C; bus.pwdata = 32'h2; bus.pstrb = 4'hF;
    @(negedge clk); bus.penable = 1'b1; ch_int_set = 8'h08;
    @(negedge clk); ch_int_set = 8'h00;
    chk("w1c_set_pready", {31'h0, bus.pready}, 32'h1);
    bus.psel = 1'b0; bus.penable = 1'b0;
    @(negedge clk);
    chk("w1c_set_wins_irq", {31'h0, irq}, 32'h1);
    apb(1, 16'h002C, 32'h2, 4'hF, rd, err, lat);
    @(negedge clk);
    chk("w1c_clear_irq", {31'h0, irq}, 32'h0);
    apb(0, 16'h002C, 0, 4'hF, rd, err, lat);
    chk("w1c_clear_read", rd, 32'h0);

    // Channel 0 DATA read that waits for rx_valid
    r0 = ren_cnt;
    fork
      apb(0, 16'h0000, 0, 4'hF, rd, err, lat);
      begin
        repeat (5) @(negedge clk);
        ch_rx_valid[0] = 1'b1; ch_rx_data[7:0] = 8'hA5;
      end
    join
    ch_rx_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("rx_wait_rdata", rd, 32'h000000A5);
    chk("rx_wait_err", {31'h0, err}, 32'h0);
    chk("rx_wait_ren_pulses", ren_cnt - r0, 1);

    // Channel 3 DATA write: timeout, then immediate push
    w0 = wen_cnt;
    apb(1, 16'h0060, 32'h5A, 4'hF, rd, err, lat);
    repeat (2) @(negedge clk);
    chk("tx_timeout_lat", lat, TIMEOUT + 1);
    chk("tx_timeout_err", {31'h0, err}, 32'h1);
    chk("tx_timeout_nowen", wen_cnt - w0, 0);
    ch_tx_wready[3] = 1'b1;
    w0 = wen_cnt;
    apb(1, 16'h0060, 32'h5A, 4'hF, rd, err, lat);
    repeat (2) @(negedge clk);
    chk("tx_push_lat", lat, 1);
    chk("tx_push_err", {31'h0, err}, 32'h0);
    chk("tx_push_wen_pulses", wen_cnt - w0, 1);
    chk("tx_push_data", {24'h0, last_tx}, 32'h5A);
    ch_tx_wready[3] = 1'b0;

    // psel dropped during WAIT: no response, no push
    w0 = wen_cnt; p0 = pready_cnt;
    @(negedge clk);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = 16'h0060; bus.pwdata = 32'h11; bus.pstrb = 4'hF;
    @(negedge clk); bus.penable = 1'b1;
    repeat (3) @(negedge clk);
    bus.psel = 1'b0; bus.penable = 1'b0;
    ch_tx_wready[3] = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort_no_pready", pready_cnt - p0, 0);
    chk("abort_no_wen", wen_cnt - w0, 0);
    ch_tx_wready[3] = 1'b0;

    // Reset asserted while waiting
    w0 = wen_cnt; p0 = pready_cnt;
    @(negedge clk);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = 16'h0060; bus.pwdata = 32'h22; bus.pstrb = 4'hF;
    @(negedge clk); bus.penable = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0; bus.psel = 1'b0; bus.penable = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("rst_wait_no_pready", pready_cnt - p0, 0);
    chk("rst_wait_no_wen", wen_cnt - w0, 0);
    apb(0, 16'h0FFC, 0, 4'hF, rd, err, lat);
    chk("rst_wait_then_id", rd, 32'hCAFE0666);
    chk("rst_wait_then_lat", lat, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
